reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  Responder end of the Dispatch->ROB allocation interface. Accepts up to DISP_WIDTH in-order
//  allocations per cycle and returns each one's ROB index. Marks entries done on FU completion
//  and retires the oldest done entries in order, up to COMMIT_WIDTH per cycle. Retirement
//  updates the architectural map and returns old physical registers to the free list.
// PARAMETERS
//  DISP_WIDTH   2   allocation lanes (matches CORE_PKG::DISP_WIDTH)
//  COMMIT_WIDTH 2   max retirements per cycle
//  CMPL_PORTS   2   completion ports (one per execution pipe)
//  ROB_DEPTH    32  entries; power of two, >= DISP_WIDTH
//  AREG_W       5   architectural register index width
//  PREG_W       7   physical register index width
//  PC_W         32  program counter width
// PORTS
//  clk             in   1                       clock
//  rst             in   1                       asynchronous, active-low reset (0 = reset)
//  alloc_valid     in   DISP_WIDTH              per-lane allocation request
//  alloc_entry     in   DISP_WIDTH x ROB_Entry  {dst_reg, dst_preg, old_preg, pc} per lane
//  alloc_ready     out  1                       free entries >= DISP_WIDTH
//  alloc_idx       out  DISP_WIDTH x IDX_W      ROB index assigned to each lane
//  cmpl_valid      in   CMPL_PORTS              completion strobe
//  cmpl_idx        in   CMPL_PORTS x IDX_W      completing ROB index
//  cmpl_exc        in   CMPL_PORTS              completion raised exception (used only with ROB_EXC_EN)
//  commit_valid    out  COMMIT_WIDTH            retiring slot valid; contiguous from slot 0
//  commit_areg     out  COMMIT_WIDTH x AREG_W   arch dst of retiring entry
//  commit_preg     out  COMMIT_WIDTH x PREG_W   new phys dst -> arch map table
//  commit_old_preg out  COMMIT_WIDTH x PREG_W   phys reg released to free list
//  flush_valid     out  1                       one-cycle pipeline flush pulse
//  flush_pc        out  PC_W                    PC of the excepting instruction
// BEHAVIOUR
//  - State: head/tail pointers of IDX_W+1 bits (wrap bit), count 0..ROB_DEPTH, and per-entry valid/done/exc bits.
//  - Reset: head=tail=count=0; all valid/done/exc = 0. Outputs: alloc_ready=1, commit_valid=0, flush_valid=0.
//    Asserting reset mid-operation discards all entries immediately.
//  - Allocate: alloc_ready = (ROB_DEPTH - count) >= DISP_WIDTH. It is computed from registered count only;
//    same-cycle commits are not counted. The request is accepted at the edge when alloc_ready=1.
//    Valid lanes take consecutive indices from tail, in lane order. Invalid lanes consume no index.
//    alloc_idx is combinational from tail. tail advances by popcount(alloc_valid).
//    alloc_valid while alloc_ready=0 is ignored; the sender holds its request.
//  - Complete: cmpl_valid sets done[cmpl_idx] (and exc) at the edge.
//    A completion to an invalid entry is ignored and fires an assertion.
//    Two ports completing the same index in one cycle fire an assertion.
//  - Commit: combinational from registered state. Slot k is valid iff slots 0..k-1 are valid and
//    entry head+k is valid and done (and has no exc). head advances by the commit count.
//    Minimum latency: alloc @N, complete @N+1, commit_valid high @N+2.
//  - Simultaneous alloc+commit: count_next = count + n_alloc - n_commit. Wrap is handled by pointer MSB;
//    full = count==ROB_DEPTH; empty = count==0 (commit_valid all 0).
// CONFIGURATION
//  ROB_EXC_EN defined: the exc bit is stored per entry. When the head entry is done with exc=1:
//    - no slot commits; flush_valid=1 for one cycle with flush_pc = that entry's pc;
//    - alloc_ready=0 and any allocation is ignored in that cycle;
//    - next edge: all valid=0, head=tail=count=0.
//  ROB_EXC_EN undefined: cmpl_exc is ignored and no exc storage exists. flush_valid=0, flush_pc=0.
// STRUCTURE
//  - CORE_PKG: ROB_DEPTH, ROB_IDX_W=$clog2(ROB_DEPTH), typedef rob_idx_t, and ROB_Entry extended
//    with dst_preg and old_preg.
//  - Sub-module rob_commit_sel: takes the head-window valid/done/exc bits and returns the
//    commit_valid vector, the commit count and the flush request.
// TESTING
//  1. Reset, then 2 lanes valid: alloc_idx={0,1}, count=2. Complete idx1 then idx0 ->
//     both commit in the same cycle, slot0=idx0.
//  2. Fill 32 entries: alloc_ready drops at count=31 (free 1 < 2). Retire 1 -> alloc_ready=1 the next cycle.
//  3. Wrap: head=30, tail=30, allocate 4 -> indices 30,31,0,1. Completing all 4 commits 2 per cycle in
//     order 30,31,0,1.
//  4. Out-of-order done: idx0 not done, idx1..3 done -> commit_valid=00. Complete idx0 -> retire 0,1,
//     then 2,3 on the following cycle.
//  5. ROB_EXC_EN: complete head with exc=1, pc=0x100 -> flush_valid=1, flush_pc=0x100, no commit.
//     Next cycle count=0, alloc_ready=1.
//  6. Reset asserted with 10 live entries -> commit_valid=0 and count=0 immediately; first
//     allocation after release gets index 0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared ROB sizing, index types and the per-lane dispatch bundle.
// ROB_EXC_EN selects exception storage and the flush path.
package reorder_buffer_pkg;

   localparam int DISP_WIDTH   = 2;
   localparam int COMMIT_WIDTH = 2;
   localparam int CMPL_PORTS   = 2;
   localparam int ROB_DEPTH    = 32;
   localparam int AREG_W       = 5;
   localparam int PREG_W       = 7;
   localparam int PC_W         = 32;
   localparam int ROB_IDX_W    = $clog2(ROB_DEPTH);

   typedef logic [ROB_IDX_W-1:0] rob_idx_t;
   typedef logic [ROB_IDX_W:0]   rob_ptr_t;

   typedef struct packed {
      logic [AREG_W-1:0] dst_reg;
      logic [PREG_W-1:0] dst_preg;
      logic [PREG_W-1:0] old_preg;
      logic [PC_W-1:0]   pc;
   } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch/completion/retire bundle between the pipeline and the ROB.
// master = pipeline side, slave = reorder_buffer.
interface reorder_buffer_if;
   import reorder_buffer_pkg::*;

   logic [DISP_WIDTH-1:0]               alloc_valid;
   rob_entry_t [DISP_WIDTH-1:0]         alloc_entry;
   logic                                alloc_ready;
   rob_idx_t [DISP_WIDTH-1:0]           alloc_idx;
   logic [CMPL_PORTS-1:0]               cmpl_valid;
   rob_idx_t [CMPL_PORTS-1:0]           cmpl_idx;
   logic [CMPL_PORTS-1:0]               cmpl_exc;
   logic [COMMIT_WIDTH-1:0]             commit_valid;
   logic [COMMIT_WIDTH-1:0][AREG_W-1:0] commit_areg;
   logic [COMMIT_WIDTH-1:0][PREG_W-1:0] commit_preg;
   logic [COMMIT_WIDTH-1:0][PREG_W-1:0] commit_old_preg;
   logic                                flush_valid;
   logic [PC_W-1:0]                     flush_pc;

   modport master (
      output alloc_valid, alloc_entry,
      output cmpl_valid, cmpl_idx, cmpl_exc,
      input  alloc_ready, alloc_idx,
      input  commit_valid, commit_areg,
      input  commit_preg, commit_old_preg,
      input  flush_valid, flush_pc
   );

   modport slave (
      input  alloc_valid, alloc_entry,
      input  cmpl_valid, cmpl_idx, cmpl_exc,
      output alloc_ready, alloc_idx,
      output commit_valid, commit_areg,
      output commit_preg, commit_old_preg,
      output flush_valid, flush_pc
   );

endinterface

// File: rtl/reorder_buffer_commit_sel.sv
// Picks the in-order retire prefix of the head window and flags
// a head exception.
module reorder_buffer_commit_sel
   import reorder_buffer_pkg::*;
(
   input  logic [COMMIT_WIDTH-1:0] win_valid,
   input  logic [COMMIT_WIDTH-1:0] win_done,
   input  logic [COMMIT_WIDTH-1:0] win_exc,
   output logic [COMMIT_WIDTH-1:0] commit_valid,
   output rob_ptr_t                commit_cnt,
   output logic                    flush
);

   logic run;

   always_comb begin
      run          = 1'b1;
      commit_valid = '0;
      commit_cnt   = '0;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         run = run & win_valid[k] & win_done[k] & ~win_exc[k];
         commit_valid[k] = run;
         commit_cnt = commit_cnt + rob_ptr_t'(run);
      end
   end

   assign flush = win_valid[0] & win_done[0] & win_exc[0];

endmodule

// File: rtl/reorder_buffer.sv
// Circular ROB: in-order allocate, out-of-order complete, in-order retire.
// Define ROB_EXC_EN to store exceptions and flush on an excepting head.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   reorder_buffer_if.slave bus
);

   rob_ptr_t             head_q, tail_q, count_q;
   logic [ROB_DEPTH-1:0] valid_q, done_q;
   logic [AREG_W-1:0]    areg_q [ROB_DEPTH];
   logic [PREG_W-1:0]    preg_q [ROB_DEPTH];
   logic [PREG_W-1:0]    old_q  [ROB_DEPTH];

   logic [COMMIT_WIDTH-1:0] win_valid, win_done, win_exc;
   logic [COMMIT_WIDTH-1:0] commit_valid;
   rob_idx_t                win_idx [COMMIT_WIDTH];
   rob_idx_t                head_idx;
   rob_ptr_t                n_commit, n_alloc, n_acc, free_cnt;
   logic                    flush, accept;

`ifdef ROB_EXC_EN
   logic [ROB_DEPTH-1:0] exc_q;
   logic [PC_W-1:0]      pc_q [ROB_DEPTH];
`else
   logic unused_in;
   always_comb begin
      unused_in = ^bus.cmpl_exc;
      for (int l = 0; l < DISP_WIDTH; l++)
         unused_in = unused_in ^ (^bus.alloc_entry[l].pc);
   end
`endif

   assign head_idx = head_q[ROB_IDX_W-1:0];

   always_comb begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         win_idx[k]   = head_idx + rob_idx_t'(k);
         win_valid[k] = valid_q[win_idx[k]];
         win_done[k]  = done_q[win_idx[k]];
`ifdef ROB_EXC_EN
         win_exc[k]   = exc_q[win_idx[k]];
`else
         win_exc[k]   = 1'b0;
`endif
      end
   end

   reorder_buffer_commit_sel u_sel (
      .win_valid    (win_valid),
      .win_done     (win_done),
      .win_exc      (win_exc),
      .commit_valid (commit_valid),
      .commit_cnt   (n_commit),
      .flush        (flush)
   );

   // Readiness ignores same-cycle retirement to keep it off the commit path.
   assign free_cnt        = rob_ptr_t'(ROB_DEPTH) - count_q;
   assign bus.alloc_ready = (free_cnt >= rob_ptr_t'(DISP_WIDTH)) && !flush;
   assign accept          = bus.alloc_ready;
   assign n_acc           = accept ? n_alloc : '0;

   always_comb begin
      n_alloc = '0;
      for (int l = 0; l < DISP_WIDTH; l++) begin
         bus.alloc_idx[l] = tail_q[ROB_IDX_W-1:0]
                          + n_alloc[ROB_IDX_W-1:0];
         n_alloc = n_alloc + rob_ptr_t'(bus.alloc_valid[l]);
      end
   end

   always_comb begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         bus.commit_areg[k]     = areg_q[win_idx[k]];
         bus.commit_preg[k]     = preg_q[win_idx[k]];
         bus.commit_old_preg[k] = old_q[win_idx[k]];
      end
   end

   assign bus.commit_valid = commit_valid;
   assign bus.flush_valid  = flush;
`ifdef ROB_EXC_EN
   assign bus.flush_pc = pc_q[head_idx];
`else
   assign bus.flush_pc = '0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         done_q  <= '0;
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         done_q  <= '0;
      end else begin
         for (int p = 0; p < CMPL_PORTS; p++)
            if (bus.cmpl_valid[p] && valid_q[bus.cmpl_idx[p]])
               done_q[bus.cmpl_idx[p]] <= 1'b1;
         for (int k = 0; k < COMMIT_WIDTH; k++)
            if (commit_valid[k]) begin
               valid_q[win_idx[k]] <= 1'b0;
               done_q[win_idx[k]]  <= 1'b0;
            end
         for (int l = 0; l < DISP_WIDTH; l++)
            if (accept && bus.alloc_valid[l]) begin
               valid_q[bus.alloc_idx[l]] <= 1'b1;
               done_q[bus.alloc_idx[l]]  <= 1'b0;
            end
         head_q  <= head_q + n_commit;
         tail_q  <= tail_q + n_acc;
         count_q <= count_q + n_acc - n_commit;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         areg_q <= '{default: '0};
         preg_q <= '{default: '0};
         old_q  <= '{default: '0};
      end else begin
         for (int l = 0; l < DISP_WIDTH; l++)
            if (accept && bus.alloc_valid[l]) begin
               areg_q[bus.alloc_idx[l]] <= bus.alloc_entry[l].dst_reg;
               preg_q[bus.alloc_idx[l]] <= bus.alloc_entry[l].dst_preg;
               old_q[bus.alloc_idx[l]]  <= bus.alloc_entry[l].old_preg;
            end
      end
   end

`ifdef ROB_EXC_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exc_q <= '0;
         pc_q  <= '{default: '0};
      end else if (flush) begin
         exc_q <= '0;
      end else begin
         for (int p = 0; p < CMPL_PORTS; p++)
            if (bus.cmpl_valid[p] && valid_q[bus.cmpl_idx[p]])
               exc_q[bus.cmpl_idx[p]] <= bus.cmpl_exc[p];
         for (int l = 0; l < DISP_WIDTH; l++)
            if (accept && bus.alloc_valid[l]) begin
               exc_q[bus.alloc_idx[l]] <= 1'b0;
               pc_q[bus.alloc_idx[l]]  <= bus.alloc_entry[l].pc;
            end
      end
   end
`endif

   for (genvar p = 0; p < CMPL_PORTS; p++) begin : g_cmpl_chk
      a_cmpl_live: assert property (@(posedge clk) disable iff (!rst)
         bus.cmpl_valid[p] |-> valid_q[bus.cmpl_idx[p]]);
      for (genvar q = p + 1; q < CMPL_PORTS; q++) begin : g_pair
         a_cmpl_uniq: assert property (@(posedge clk) disable iff (!rst)
            !(bus.cmpl_valid[p] && bus.cmpl_valid[q]
              && bus.cmpl_idx[p] == bus.cmpl_idx[q]));
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic
// scored against a queue model of the in-flight window.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   reorder_buffer_if bus();

   reorder_buffer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int                idx;
      logic [AREG_W-1:0] areg;
      logic [PREG_W-1:0] preg;
      logic [PREG_W-1:0] old;
      logic [PC_W-1:0]   pc;
      bit                done;
      bit                exc;
   } m_ent_t;

   m_ent_t rob[$];
   int     tail_m = 0;
   int     errors = 0;
   int     checks = 0;

   logic [DISP_WIDTH-1:0] s_alloc;
   int                    s_cidx [CMPL_PORTS];
   bit                    s_cexc [CMPL_PORTS];
   bit                    fix_pc = 1'b0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_stim(input logic [DISP_WIDTH-1:0] a,
                           input int c0, input int c1);
      s_alloc   = a;
      s_cidx[0] = c0;
      s_cidx[1] = c1;
      s_cexc[0] = 1'b0;
      s_cexc[1] = 1'b0;
   endtask

   task automatic drive_idle();
      bus.alloc_valid = '0;
      bus.alloc_entry = '0;
      bus.cmpl_valid  = '0;
      bus.cmpl_idx    = '0;
      bus.cmpl_exc    = '0;
   endtask

   task automatic cmpl_oldest();
      int n = 0;
      foreach (rob[i])
         if (!rob[i].done && n < CMPL_PORTS) begin
            s_cidx[n] = rob[i].idx;
            n++;
         end
   endtask

   task automatic cmpl_rand();
      int cand[$];
      int j;
      foreach (rob[i])
         if (!rob[i].done) cand.push_back(rob[i].idx);
      for (int p = 0; p < CMPL_PORTS; p++) begin
         s_cidx[p] = -1;
`ifdef ROB_EXC_EN
         s_cexc[p] = ($urandom_range(0, 63) == 0);
`else
         s_cexc[p] = 1'($urandom);
`endif
         if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
            j = $urandom_range(0, cand.size() - 1);
            s_cidx[p] = cand[j];
            cand.delete(j);
         end
      end
   endtask

   task automatic step();
      int ncm, off;
      bit fl, rdy;
      logic [COMMIT_WIDTH-1:0] cv_exp;
      m_ent_t e;
      @(negedge clk);
      bus.alloc_valid = s_alloc;
      for (int l = 0; l < DISP_WIDTH; l++) begin
         bus.alloc_entry[l].dst_reg  = AREG_W'($urandom);
         bus.alloc_entry[l].dst_preg = PREG_W'($urandom);
         bus.alloc_entry[l].old_preg = PREG_W'($urandom);
         bus.alloc_entry[l].pc = fix_pc ? 32'h100 : $urandom;
      end
      for (int p = 0; p < CMPL_PORTS; p++) begin
         bus.cmpl_valid[p] = (s_cidx[p] >= 0);
         bus.cmpl_idx[p]   = rob_idx_t'(s_cidx[p] < 0 ? 0 : s_cidx[p]);
         bus.cmpl_exc[p]   = s_cexc[p];
      end
      #1;
      fl = 1'b0;
`ifdef ROB_EXC_EN
      fl = rob.size() > 0 && rob[0].done && rob[0].exc;
`endif
      rdy = (ROB_DEPTH - rob.size()) >= DISP_WIDTH && !fl;
      ncm = 0;
      if (!fl)
         while (ncm < COMMIT_WIDTH && ncm < rob.size()
                && rob[ncm].done && !rob[ncm].exc)
            ncm++;
      cv_exp = COMMIT_WIDTH'((1 << ncm) - 1);
      check("alloc_ready", 64'(bus.alloc_ready), 64'(rdy));
      check("count", 64'(dut.count_q), 64'(rob.size()));
      check("commit_valid", 64'(bus.commit_valid), 64'(cv_exp));
      check("flush_valid", 64'(bus.flush_valid), 64'(fl));
`ifdef ROB_EXC_EN
      if (fl) check("flush_pc", 64'(bus.flush_pc), 64'(rob[0].pc));
`else
      check("flush_pc", 64'(bus.flush_pc), 64'd0);
`endif
      for (int k = 0; k < ncm; k++) begin
         check("commit_areg", 64'(bus.commit_areg[k]), 64'(rob[k].areg));
         check("commit_preg", 64'(bus.commit_preg[k]), 64'(rob[k].preg));
         check("commit_old", 64'(bus.commit_old_preg[k]), 64'(rob[k].old));
      end
      off = 0;
      for (int l = 0; l < DISP_WIDTH; l++)
         if (s_alloc[l]) begin
            check("alloc_idx", 64'(bus.alloc_idx[l]),
                  64'((tail_m + off) % ROB_DEPTH));
            off++;
         end
      @(posedge clk);
      if (fl) begin
         rob.delete();
         tail_m = 0;
      end else begin
         repeat (ncm) void'(rob.pop_front());
         for (int p = 0; p < CMPL_PORTS; p++)
            if (s_cidx[p] >= 0)
               foreach (rob[i])
                  if (rob[i].idx == s_cidx[p]) begin
                     rob[i].done = 1'b1;
`ifdef ROB_EXC_EN
                     rob[i].exc = s_cexc[p];
`endif
                  end
         if (rdy)
            for (int l = 0; l < DISP_WIDTH; l++)
               if (s_alloc[l]) begin
                  e.idx  = tail_m;
                  e.areg = bus.alloc_entry[l].dst_reg;
                  e.preg = bus.alloc_entry[l].dst_preg;
                  e.old  = bus.alloc_entry[l].old_preg;
                  e.pc   = bus.alloc_entry[l].pc;
                  e.done = 1'b0;
                  e.exc  = 1'b0;
                  rob.push_back(e);
                  tail_m = (tail_m + 1) % ROB_DEPTH;
               end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      drive_idle();
      #1;
      check("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
      check("rst_count", 64'(dut.count_q), 64'd0);
      check("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
      check("rst_flush_valid", 64'(bus.flush_valid), 64'd0);
      rob.delete();
      tail_m = 0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      drive_idle();
      set_stim('0, -1, -1);

      // two lanes, completed out of order, retire together
      do_reset();
      set_stim(2'b11, -1, -1); step();
      set_stim(2'b00, 1, -1);  step();
      set_stim(2'b00, 0, -1);  step();
      set_stim(2'b00, -1, -1); step(); step();

      // fill to 31, then free one slot
      do_reset();
      repeat (15) begin set_stim(2'b11, -1, -1); step(); end
      set_stim(2'b01, -1, -1); step();
      set_stim(2'b11, 0, -1);  step();
      set_stim(2'b11, -1, -1); step(); step(); step();

      // pointer wrap at 30
      do_reset();
      repeat (15) begin set_stim(2'b11, -1, -1); cmpl_oldest(); step(); end
      for (int i = 0; i < 64 && rob.size() > 0; i++) begin
         set_stim(2'b00, -1, -1); cmpl_oldest(); step();
      end
      set_stim(2'b11, -1, -1); step(); step();
      set_stim(2'b00, 30, 31); step();
      set_stim(2'b00, 0, 1);   step();
      set_stim(2'b00, -1, -1); step(); step();

      // head not done blocks younger done entries
      do_reset();
      set_stim(2'b11, -1, -1); step(); step();
      set_stim(2'b00, 1, 2);   step();
      set_stim(2'b00, 3, -1);  step();
      set_stim(2'b00, -1, -1); step();
      set_stim(2'b00, 0, -1);  step();
      set_stim(2'b00, -1, -1); step(); step(); step();

`ifdef ROB_EXC_EN
      do_reset();
      fix_pc = 1'b1;
      set_stim(2'b11, -1, -1); step();
      fix_pc = 1'b0;
      set_stim(2'b00, 0, 1);
      s_cexc[0] = 1'b1;
      step();
      set_stim(2'b11, -1, -1); step();
      set_stim(2'b00, -1, -1); step();
      set_stim(2'b01, -1, -1); step();
`endif

      // reset with live entries whose head pair is retiring
      do_reset();
      repeat (5) begin set_stim(2'b11, -1, -1); step(); end
      set_stim(2'b00, 0, 1); step();
      #1;
      check("pre_rst_commit", 64'(bus.commit_valid), 64'h3);
      do_reset();
      set_stim(2'b01, -1, -1); step();
      set_stim(2'b00, -1, -1); step();

      // random traffic
      do_reset();
      repeat (3000) begin
         s_alloc = DISP_WIDTH'($urandom);
         cmpl_rand();
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
